// File: rtl/spm_pkg.sv
// Shared constants and FSM state type for the dual-port scratchpad.
package spm_pkg;

  localparam logic ENABLE  = 1'b0;
  localparam logic DISABLE = 1'b1;
  localparam logic WRITE   = 1'b0;
  localparam logic READ    = 1'b1;

  typedef enum logic {
    CLEAR,
    READY
  } spm_state_e;

endpackage

// File: rtl/dpram_be.sv
// True dual-port RAM with per-byte write enables and read-first ports.
// Callers must keep addresses in range and never write the same byte from
// both ports in one cycle.
module dpram_be #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4096,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic [BE_W-1:0]   a_we_i,
  input  logic              a_re_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic [BE_W-1:0]   b_we_i,
  input  logic              b_re_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic [DATA_W-1:0] b_rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Both ports in one block so the array has a single driver; reads see the old word.
  always_ff @(posedge clk_i) begin
    if (a_re_i) a_rdata_q <= mem[a_addr_i];
    if (b_re_i) b_rdata_q <= mem[b_addr_i];
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (b_we_i[i]) mem[b_addr_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
      if (a_we_i[i]) mem[a_addr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/spm_dp.sv
// Dual-port byte-writable scratchpad with a hardware clear sequencer.
// Port A (spm) wins per byte on same-address write collisions.
// Define SPM_DP_FWD_EN to forward same-cycle cross-port writes into reads;
// by default such a read returns the pre-write word.
module spm_dp
  import spm_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4096,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              spm_clr,
  input  logic              if_spm_asn,
  input  logic              if_spm_rw,
  input  logic [BE_W-1:0]   if_spm_be,
  input  logic [ADDR_W-1:0] if_spm_addr,
  input  logic [DATA_W-1:0] if_spm_wdata,
  output logic [DATA_W-1:0] if_spm_rdata,
  output logic              if_spm_rvalid,
  input  logic              if_mem_asn,
  input  logic              if_mem_rw,
  input  logic [BE_W-1:0]   if_mem_be,
  input  logic [ADDR_W-1:0] if_mem_addr,
  input  logic [DATA_W-1:0] if_mem_wdata,
  output logic [DATA_W-1:0] if_mem_rdata,
  output logic              if_mem_rvalid,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  spm_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;

  logic              go, acc_a, acc_b, rd_a, rd_b, wr_a, wr_b, inr_a, inr_b, same_addr;
  logic [BE_W-1:0]   wbe_a, wbe_b, fwd_a_be, fwd_b_be;
  logic [BE_W-1:0]   ram_a_we;
  logic [ADDR_W-1:0] ram_a_addr;
  logic [DATA_W-1:0] ram_a_wdata, ram_a_rd, ram_b_rd;

  logic              rvalid_a_q, rvalid_b_q, oor_a_q, oor_b_q;
  logic [BE_W-1:0]   fwd_a_be_q, fwd_b_be_q;
  logic [DATA_W-1:0] fwd_a_data_q, fwd_b_data_q, hold_a_q, hold_b_q;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  assign busy = (state_q == CLEAR);

  // Accesses are dropped while clearing, under reset, and in the cycle a clear is requested.
  assign go    = (state_q == READY) && !cpu_rst && !spm_clr;
  assign acc_a = go && (if_spm_asn == ENABLE);
  assign acc_b = go && (if_mem_asn == ENABLE);
  assign rd_a  = acc_a && (if_spm_rw == READ);
  assign rd_b  = acc_b && (if_mem_rw == READ);
  assign wr_a  = acc_a && (if_spm_rw == WRITE);
  assign wr_b  = acc_b && (if_mem_rw == WRITE);
  assign inr_a = ({1'b0, if_spm_addr} < DEPTH_X);
  assign inr_b = ({1'b0, if_mem_addr} < DEPTH_X);
  assign same_addr = (if_spm_addr == if_mem_addr);

  // Port B loses any byte that port A also writes at the same address.
  assign wbe_a = (wr_a && inr_a) ? if_spm_be : '0;
  assign wbe_b = (wr_b && inr_b) ? (same_addr ? (if_mem_be & ~wbe_a) : if_mem_be) : '0;

`ifdef SPM_DP_FWD_EN
  assign fwd_a_be = (rd_a && same_addr) ? wbe_b : '0;
  assign fwd_b_be = (rd_b && same_addr) ? wbe_a : '0;
`else
  assign fwd_a_be = '0;
  assign fwd_b_be = '0;
`endif

  // The clear sequencer borrows the port A write path; port A accesses are idle then.
  assign ram_a_we    = busy ? ((!cpu_rst) ? '1 : '0) : wbe_a;
  assign ram_a_addr  = busy ? cnt_q : if_spm_addr;
  assign ram_a_wdata = busy ? '0 : if_spm_wdata;

  dpram_be #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk_i     (cpu_clk),
    .a_we_i    (ram_a_we),
    .a_re_i    (rd_a && inr_a),
    .a_addr_i  (ram_a_addr),
    .a_wdata_i (ram_a_wdata),
    .a_rdata_o (ram_a_rd),
    .b_we_i    (wbe_b),
    .b_re_i    (rd_b && inr_b),
    .b_addr_i  (if_mem_addr),
    .b_wdata_i (if_mem_wdata),
    .b_rdata_o (ram_b_rd)
  );

  // Clear sequencer: walks every word once, then waits for the next clear request.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == ADDR_W'(DEPTH - 1)) state_q <= READY;
        end
        READY: begin
          if (spm_clr) begin
            cnt_q   <= '0;
            state_q <= CLEAR;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Read-side sideband captured alongside the RAM read: valid, out-of-range, forward bytes.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      rvalid_a_q   <= 1'b0;
      rvalid_b_q   <= 1'b0;
      oor_a_q      <= 1'b0;
      oor_b_q      <= 1'b0;
      fwd_a_be_q   <= '0;
      fwd_b_be_q   <= '0;
      fwd_a_data_q <= '0;
      fwd_b_data_q <= '0;
      hold_a_q     <= '0;
      hold_b_q     <= '0;
    end else begin
      rvalid_a_q   <= rd_a;
      rvalid_b_q   <= rd_b;
      oor_a_q      <= rd_a && !inr_a;
      oor_b_q      <= rd_b && !inr_b;
      fwd_a_be_q   <= fwd_a_be;
      fwd_b_be_q   <= fwd_b_be;
      fwd_a_data_q <= if_mem_wdata;
      fwd_b_data_q <= if_spm_wdata;
      hold_a_q     <= rdata_a;
      hold_b_q     <= rdata_b;
    end
  end

  // Output data: hold the last value unless a read completes, then merge forwarded bytes.
  always_comb begin
    rdata_a = hold_a_q;
    rdata_b = hold_b_q;
    if (rvalid_a_q) begin
      for (int unsigned i = 0; i < BE_W; i++)
        rdata_a[i*8 +: 8] = fwd_a_be_q[i] ? fwd_a_data_q[i*8 +: 8] : ram_a_rd[i*8 +: 8];
      if (oor_a_q) rdata_a = '0;
    end
    if (rvalid_b_q) begin
      for (int unsigned i = 0; i < BE_W; i++)
        rdata_b[i*8 +: 8] = fwd_b_be_q[i] ? fwd_b_data_q[i*8 +: 8] : ram_b_rd[i*8 +: 8];
      if (oor_b_q) rdata_b = '0;
    end
  end

  assign if_spm_rdata  = rdata_a;
  assign if_mem_rdata  = rdata_b;
  assign if_spm_rvalid = rvalid_a_q;
  assign if_mem_rvalid = rvalid_b_q;

endmodule

// File: tb/tb_spm_dp.sv
// Directed self-checking bench for spm_dp at DATA_W=32, DEPTH=16.
module tb_spm_dp;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic        a_asn, a_rw, b_asn, b_rw;
  logic [3:0]  a_be, b_be, a_addr, b_addr;
  logic [31:0] a_wd, b_wd, a_rd, b_rd;
  logic        a_rv, b_rv, busy;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  spm_dp #(.DATA_W(32), .DEPTH(16)) dut (
    .cpu_clk       (clk),
    .cpu_rst       (rst),
    .spm_clr       (clr),
    .if_spm_asn    (a_asn),
    .if_spm_rw     (a_rw),
    .if_spm_be     (a_be),
    .if_spm_addr   (a_addr),
    .if_spm_wdata  (a_wd),
    .if_spm_rdata  (a_rd),
    .if_spm_rvalid (a_rv),
    .if_mem_asn    (b_asn),
    .if_mem_rw     (b_rw),
    .if_mem_be     (b_be),
    .if_mem_addr   (b_addr),
    .if_mem_wdata  (b_wd),
    .if_mem_rdata  (b_rd),
    .if_mem_rvalid (b_rv),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_asn = 1'b1; b_asn = 1'b1;
  endtask

  task automatic acc_a(input logic rw, input logic [3:0] addr, input logic [3:0] be, input logic [31:0] d);
    a_asn = 1'b0; a_rw = rw; a_addr = addr; a_be = be; a_wd = d;
  endtask

  task automatic acc_b(input logic rw, input logic [3:0] addr, input logic [3:0] be, input logic [31:0] d);
    b_asn = 1'b0; b_rw = rw; b_addr = addr; b_be = be; b_wd = d;
  endtask

  logic [31:0] exp_fwd1, exp_fwd2;

  initial begin
`ifdef SPM_DP_FWD_EN
    exp_fwd1 = 32'h0000_0009;
    exp_fwd2 = 32'hFFFF_0009;
`else
    exp_fwd1 = 32'h0000_0005;
    exp_fwd2 = 32'h0000_0009;
`endif
    rst = 1'b1; clr = 1'b0;
    a_rw = 1'b1; b_rw = 1'b1; a_be = '0; b_be = '0;
    a_addr = '0; b_addr = '0; a_wd = '0; b_wd = '0;
    idle();

    // Reset state
    cyc();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_a_rd", a_rd, 32'h0);
    chk("rst_b_rd", b_rd, 32'h0);
    chk("rst_a_rv", 32'(a_rv), 32'd0);
    chk("rst_b_rv", 32'(b_rv), 32'd0);
    rst = 1'b0;

    // Initial clear: 16 cycles busy, then ready
    for (int i = 2; i <= 16; i++) begin
      cyc();
      chk("init_busy", 32'(busy), 32'd1);
    end
    cyc();
    chk("init_done", 32'(busy), 32'd0);

    // Cleared word reads zero, valid next cycle
    acc_a(1'b1, 4'd5, 4'h0, 32'h0);
    cyc();
    chk("rd5_rv", 32'(a_rv), 32'd1);
    chk("rd5_data", a_rd, 32'h0);

    // Byte-enabled write
    acc_a(1'b0, 4'd3, 4'b0101, 32'hAABB_CCDD);
    cyc();
    chk("wr3_rv", 32'(a_rv), 32'd0);
    acc_a(1'b1, 4'd3, 4'h0, 32'h0);
    cyc();
    chk("rd3_data", a_rd, 32'h00BB_00DD);

    // Same-address write collision, A wins per byte
    acc_a(1'b0, 4'd7, 4'b0011, 32'h1111_1111);
    acc_b(1'b0, 4'd7, 4'b1111, 32'h2222_2222);
    cyc();
    acc_a(1'b1, 4'd7, 4'h0, 32'h0);
    acc_b(1'b1, 4'd7, 4'h0, 32'h0);
    cyc();
    chk("col_a", a_rd, 32'h2222_1111);
    chk("col_b", b_rd, 32'h2222_1111);
    chk("col_brv", 32'(b_rv), 32'd1);

    // Idle: rvalid drops, data holds
    idle();
    cyc();
    chk("idle_arv", 32'(a_rv), 32'd0);
    chk("idle_brv", 32'(b_rv), 32'd0);
    chk("idle_ahold", a_rd, 32'h2222_1111);
    chk("idle_bhold", b_rd, 32'h2222_1111);

    // Cross-port write/read in one cycle
    acc_a(1'b0, 4'd9, 4'hF, 32'h5);
    cyc();
    acc_a(1'b0, 4'd9, 4'hF, 32'h9);
    acc_b(1'b1, 4'd9, 4'h0, 32'h0);
    cyc();
    chk("xrd_b", b_rd, exp_fwd1);
    acc_a(1'b1, 4'd9, 4'h0, 32'h0);
    acc_b(1'b0, 4'd9, 4'b1100, 32'hFFFF_0000);
    cyc();
    chk("xrd_a", a_rd, exp_fwd2);

    // be=0 write leaves the word alone
    acc_a(1'b0, 4'd9, 4'h0, 32'hDEAD_BEEF);
    idle(); a_asn = 1'b0;
    cyc();
    acc_a(1'b1, 4'd9, 4'h0, 32'h0);
    cyc();
    chk("be0_data", a_rd, 32'hFFFF_0009);

    // Clear request discards the concurrent access
    clr = 1'b1;
    acc_a(1'b0, 4'd3, 4'hF, 32'hFFFF_FFFF);
    acc_b(1'b1, 4'd7, 4'h0, 32'h0);
    cyc();
    clr = 1'b0;
    chk("clr_busy", 32'(busy), 32'd1);
    chk("clr_brv", 32'(b_rv), 32'd0);
    chk("clr_arv", 32'(a_rv), 32'd0);

    // Reads while busy produce nothing
    acc_a(1'b1, 4'd2, 4'h0, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("bsy_arv", 32'(a_rv), 32'd0);
      chk("bsy_brv", 32'(b_rv), 32'd0);
      chk("bsy_busy", 32'(busy), 32'd1);
    end

    // Reset mid-clear restarts the clear
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd1);
    chk("mrst_ard", a_rd, 32'h0);
    chk("mrst_brd", b_rd, 32'h0);

    // Writes during restarted clear are ignored; clear requests do not restart it
    acc_a(1'b0, 4'd0, 4'hF, 32'h7777_7777);
    acc_b(1'b0, 4'd1, 4'hF, 32'h6666_6666);
    for (int k = 1; k <= 15; k++) begin
      clr = (k == 4 || k == 10);
      cyc();
      chk("rclr_busy", 32'(busy), 32'd1);
    end
    clr = 1'b0;
    cyc();
    chk("rclr_done", 32'(busy), 32'd0);

    // Every word reads zero on both ports
    for (int i = 0; i < 16; i++) begin
      acc_a(1'b1, 4'(i), 4'h0, 32'h0);
      acc_b(1'b1, 4'(15 - i), 4'h0, 32'h0);
      cyc();
      chk("zero_a", a_rd, 32'h0);
      chk("zero_b", b_rd, 32'h0);
      chk("zero_arv", 32'(a_rv), 32'd1);
      chk("zero_brv", 32'(b_rv), 32'd1);
    end
    idle();
    cyc();
    chk("end_arv", 32'(a_rv), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/spm_dp.md
SPM_DP -- requirements
Module: spm_dp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width per port, a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 4096: number of words, at least 2.
REQ-003 SHALL derive localparams ADDR_W=$clog2(DEPTH) and BE_W=DATA_W/8; these are not overridable.
REQ-004 Ports, in order:
- cpu_clk  in  1  clock; sole clock.
- cpu_rst  in  1  reset; synchronous, active-high.
- spm_clr  in  1  clear request pulse.
- if_spm_asn  in  1  port A select; 0=ENABLE.
- if_spm_rw  in  1  port A direction; 0=WRITE, 1=READ.
- if_spm_be  in  BE_W  port A byte enables, write only.
- if_spm_addr  in  ADDR_W  port A word address.
- if_spm_wdata  in  DATA_W  port A write data.
- if_spm_rdata  out  DATA_W  port A read data.
- if_spm_rvalid  out  1  port A read data valid.
- if_mem_asn / if_mem_rw / if_mem_be / if_mem_addr / if_mem_wdata  in  port B, same meanings as port A.
- if_mem_rdata  out  DATA_W  port B read data.
- if_mem_rvalid  out  1  port B read data valid.
- busy  out  1  clear in progress; accesses are ignored.

Function
REQ-005 SHALL accept a port access in a cycle only when asn=0 and busy=0.
REQ-006 SHALL, on an accepted read at cycle N, drive rdata=mem[addr] and rvalid=1 at cycle N+1.
REQ-007 SHALL set rvalid=0 in every cycle that follows a non-read or non-accepted cycle; rdata SHALL hold its last value in those cycles.
REQ-008 SHALL, on an accepted write, update only the bytes whose be bit is 1; be=0 SHALL leave the word unchanged.
REQ-009 SHALL, when both ports write the same address in one cycle, give port A (spm) priority per byte; port B bytes not enabled on A SHALL still be written.
REQ-010 SHALL, when one port reads an address that the other port writes in the same cycle, return data according to REQ-022.
REQ-011 SHALL, when both ports read the same address in one cycle, return identical data on both ports.
REQ-012 SHALL ignore a write to an address >= DEPTH; a read of an address >= DEPTH SHALL return rdata=0 with rvalid=1.
REQ-013 SHALL implement FSM states CLEAR and READY.
- CLEAR: write zero to word cnt each cycle and increment cnt; busy=1; go to READY after writing word DEPTH-1.
- READY: busy=0; spm_clr=1 sets cnt=0 and goes to CLEAR.
REQ-014 SHALL make a full clear last exactly DEPTH cycles, with busy=0 in the cycle after the last zero write.
REQ-015 SHALL ignore spm_clr while in CLEAR; the clear SHALL not restart.
REQ-016 SHALL discard a port access presented in the same cycle that spm_clr is sampled in READY; that access SHALL not write and SHALL not set rvalid.

Reset
REQ-017 SHALL, with cpu_rst=1 at a clock edge, set state=CLEAR, cnt=0, busy=1, both rdata=0 and both rvalid=0.
REQ-018 SHALL restart an in-progress clear from address 0 when reset is asserted mid-clear.
REQ-019 SHALL perform no memory write from either port while cpu_rst=1.

Configuration
REQ-020 Macro SPM_DP_FWD_EN SHALL select cross-port write-to-read forwarding.
REQ-021 Without SPM_DP_FWD_EN, a same-cycle cross-port read SHALL return the pre-write (old) word.
REQ-022 With SPM_DP_FWD_EN, a same-cycle cross-port read SHALL return the post-write word, with the enabled bytes merged and REQ-009 priority applied.

Structure
REQ-023 SHALL take the ENABLE=0, DISABLE=1, WRITE=0 and READ=1 constants, and the FSM state enum, from package spm_pkg.
REQ-024 SHALL place the storage array in a sub-module dpram_be: two synchronous ports, per-byte write enables, read-first behaviour.
REQ-025 SHALL keep collision resolution, forwarding and the clear FSM in spm_dp; the clear SHALL drive the port A write path of dpram_be.

Verification (DATA_W=32, DEPTH=16)
REQ-026 Reset, then wait 16 cycles -> busy=1 for cycles 1..16, busy=0 at cycle 17; a read of address 5 returns 0x00000000 with rvalid one cycle after the read.
REQ-027 Port A writes 0xAABBCCDD to address 3 with be=4'b0101, over an initial value of 0 -> a later read of address 3 returns 0x00BB00DD.
REQ-028 Same cycle: A writes 0x11111111 with be=4'b0011 and B writes 0x22222222 with be=4'b1111, both to address 7 -> address 7 holds 0x22221111.
REQ-029 Address 9 holds 0x5; A writes 0x9 to it while B reads it in the same cycle -> B rdata=0x5 without SPM_DP_FWD_EN and 0x9 with it.
REQ-030 Pulse spm_clr after writes, then assert cpu_rst at clear cycle 6 -> clear restarts at address 0, busy=1 for 16 further cycles, all words read back 0.
REQ-031 Accesses on both ports while busy=1 -> no write takes effect and both rvalid stay 0.
